// File: rtl/unified_mem_arbiter_if.sv
// Cache-side request/response and memory-side drive signals of the unified memory arbiter.
// The arbiter takes the slave view; the caches and memory model take the master view.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic [DATA_W-1:0] ic_rdata;
    logic              ic_done;
    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_done;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdy;
    logic              busy;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_rdy,
        output ic_rdata, ic_done, dc_rdata, dc_done, err, mem_addr, mem_re, mem_we,
               mem_wdata, busy
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_rdy,
        input  ic_rdata, ic_done, dc_rdata, dc_done, err, mem_addr, mem_re, mem_we,
               mem_wdata, busy
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-outstanding arbiter between I-cache and D-cache traffic in front of the unified memory.
// D wins ties unless it won last; watchdog aborts a granted access that never sees mem_rdy.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input logic clk,
    input logic rst,
    unified_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state;
    logic              last_d;
    logic [7:0]        cnt;
    logic              busy_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] ic_rdata_q;
    logic [DATA_W-1:0] dc_rdata_q;
    logic              ic_done_q;
    logic              dc_done_q;
    logic              err_q;

    logic i_elig, d_elig, pick_i, pick_d, timeout;
    req_t i_req, d_req, win;

    // A requester still holding req during its own done pulse is not a new request.
    assign i_elig  = bus.ic_req & ~ic_done_q;
    assign d_elig  = bus.dc_req & ~dc_done_q;
    assign pick_d  = d_elig & (~i_elig | ~last_d);
    assign pick_i  = i_elig & ~pick_d;
    assign timeout = (cnt == 8'(TIMEOUT - 1));

    assign i_req = '{addr: bus.ic_addr, we: 1'b0, wdata: '0};
    assign d_req = '{addr: bus.dc_addr, we: bus.dc_we, wdata: bus.dc_wdata};
    assign win   = pick_d ? d_req : i_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_d      <= 1'b0;
            cnt         <= '0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
            ic_done_q   <= 1'b0;
            dc_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
            err_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_d | pick_i) begin
                        state       <= pick_d ? GNT_D : GNT_I;
                        last_d      <= pick_d;
                        mem_addr_q  <= win.addr;
                        mem_wdata_q <= win.wdata;
                        mem_re_q    <= ~win.we;
                        mem_we_q    <= win.we;
                        cnt         <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                GNT_I, GNT_D: begin
                    cnt <= cnt + 8'd1;
                    // mem_rdy wins over the watchdog when both land in the same cycle
                    if (bus.mem_rdy || timeout) begin
                        state    <= DONE;
                        mem_re_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        err_q    <= ~bus.mem_rdy;
                        if (state == GNT_I) ic_done_q <= 1'b1;
                        else                dc_done_q <= 1'b1;
                        if (bus.mem_rdy && mem_re_q) begin
                            if (state == GNT_I) ic_rdata_q <= bus.mem_rdata;
                            else                dc_rdata_q <= bus.mem_rdata;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.ic_rdata  = ic_rdata_q;
    assign bus.dc_rdata  = dc_rdata_q;
    assign bus.ic_done   = ic_done_q;
    assign bus.dc_done   = dc_done_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
endmodule
